// File: rtl/br_sync_fifo_fwft.sv
// Single-clock FIFO with selectable first-word-fall-through or standard read timing,
// occupancy flags and sticky overflow/underflow flags.
module br_sync_fifo_fwft #(
    parameter int WIDTH     = 256,
    parameter int PTR       = 10,
    parameter int DEPTH     = 1024,
    parameter int AF_THRESH = DEPTH - 16,
    parameter int AE_THRESH = 16,
    parameter int FWFT      = 1
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             srst,
    input  logic             wrreq,
    input  logic [WIDTH-1:0] data,
    output logic             full,
    output logic             almost_full,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             almost_empty,
    output logic [PTR:0]     usedw,
    output logic             ovf,
    output logic             udf,
    input  logic             clr_err
);
    localparam int CW = PTR + 1;

    localparam logic [PTR:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [PTR:0]   AF_C    = CW'(AF_THRESH);
    localparam logic [PTR:0]   AE_C    = CW'(AE_THRESH);
    localparam logic [PTR:0]   CNT_ONE = CW'(1);
    localparam logic [PTR-1:0] PTR_ONE = PTR'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR:0]     usedw_q, usedw_d;
    logic [WIDTH-1:0] q_q;
    logic             qv_q, qv_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             wr_acc;
    logic             rd_acc;
    logic             load;
    logic [PTR:0]     mem_cnt;

    // In FWFT mode the output register holds the head word; qv_q says it is valid.
    assign full         = (usedw_q == DEPTH_C);
    assign empty        = (FWFT != 0) ? !qv_q : (usedw_q == '0);
    assign almost_full  = (usedw_q >= AF_C);
    assign almost_empty = (usedw_q <= AE_C);
    assign usedw        = usedw_q;
    assign q            = q_q;
    assign ovf          = ovf_q;
    assign udf          = udf_q;

    always_comb begin
        // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
        wr_acc   = wrreq && !full;
        rd_acc   = rdreq && !empty;
        mem_cnt  = usedw_q - {{PTR{1'b0}}, qv_q};
        load     = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usedw_d  = usedw_q;
        qv_d     = qv_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        // Words still in RAM were written on an earlier edge, so they can be loaded now.
        if (FWFT != 0) begin
            load = (!qv_q || rd_acc) && (mem_cnt != '0);
        end else begin
            load = rd_acc;
        end

        if (srst) begin
            load     = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usedw_d  = '0;
            qv_d     = 1'b0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (load) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end

            case ({wr_acc, rd_acc})
                2'b10:   usedw_d = usedw_q + CNT_ONE;
                2'b01:   usedw_d = usedw_q - CNT_ONE;
                default: usedw_d = usedw_q;
            endcase

            if (FWFT != 0) begin
                qv_d = load || (qv_q && !rd_acc);
            end

            // A fresh error wins over a coincident clear.
            ovf_d = (wrreq && full) || (ovf_q && !clr_err);
            udf_d = (rdreq && empty) || (udf_q && !clr_err);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            qv_q     <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            q_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            qv_q     <= qv_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            if (srst) begin
                q_q <= '0;
            end else if (load) begin
                q_q <= mem[rd_ptr_q];
            end
        end
    end

    // NOTE: storage has no reset; pointers and usedw alone define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_acc && !srst) begin
            mem[wr_ptr_q] <= data;
        end
    end

endmodule
